proj_trg_gen: RTL and testbench

Projector-trigger sequencer that generates the PROJ_TRG pulse train consumed by the LED controller, with programmable period, high time and frame count. It also monitors the LED controller's active-low trigger bus and counts frames in which no LED fired ("miss"). It sits between the host register file and the LED controller, on the same clock.

---
 rtl/proj_trg_gen.sv | 125 ++++++++++++
 tb/tb_proj_trg_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/proj_trg_gen.sv
// rtl/proj_trg_gen.sv - projector trigger sequencer with LED-ack miss counter
module proj_trg_gen #(
  parameter int MISS_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [31:0]       TrgPeriod,
  input  logic [31:0]       TrgHigh,
  input  logic [31:0]       TrgCount,
  input  logic [7:0]        trig_in,
  output logic              PROJ_TRG,
  output logic              busy,
  output logic              done,
  output logic [31:0]       frame_cnt,
  output logic [MISS_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  state_t      state;
  logic [31:0] cnt;        // cycles remaining in the current HIGH/LOW phase, minus one
  logic [31:0] high_m1;    // latched H-1
  logic [31:0] low_m1;     // latched P-H-1
  logic [31:0] n_frames;   // latched frame limit, 0 = run until stop
  logic        ack_seen;
  logic        stop_pend;

  logic        hit;
  logic [31:0] cfg_h;
  logic [31:0] cfg_low_m1;
  logic        last_frame;

  // Clamp the live config (H >= 1, P >= H+1) and decode the ack bus and frame limit
  always_comb begin
    hit        = (trig_in != 8'hFF);
    cfg_h      = (TrgHigh == 32'd0) ? 32'd1 : TrgHigh;
    cfg_low_m1 = (TrgPeriod > cfg_h) ? (TrgPeriod - cfg_h - 32'd1) : 32'd0;
    last_frame = (n_frames != 32'd0) && ((frame_cnt + 32'd1) == n_frames);
  end

  // Sequencer: phase counters, ack/miss bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      PROJ_TRG  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= 32'd0;
      miss_cnt  <= '0;
      ack_seen  <= 1'b0;
      stop_pend <= 1'b0;
      cnt       <= 32'd0;
      high_m1   <= 32'd0;
      low_m1    <= 32'd0;
      n_frames  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          PROJ_TRG <= 1'b0;
          if (start) begin
            high_m1   <= cfg_h - 32'd1;
            low_m1    <= cfg_low_m1;
            n_frames  <= TrgCount;
            cnt       <= cfg_h - 32'd1;
            frame_cnt <= 32'd0;
            miss_cnt  <= '0;
            ack_seen  <= 1'b0;
            stop_pend <= 1'b0;
            PROJ_TRG  <= 1'b1;
            busy      <= 1'b1;
            state     <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (hit)  ack_seen  <= 1'b1;
          if (stop) stop_pend <= 1'b1;
          if (cnt == 32'd0) begin
            state    <= S_LOW;
            PROJ_TRG <= 1'b0;
            cnt      <= low_m1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        S_LOW: begin
          if (hit)  ack_seen  <= 1'b1;
          if (stop) stop_pend <= 1'b1;
          if (cnt != 32'd0) begin
            cnt <= cnt - 32'd1;
          end else begin
            // Last cycle of the period: a hit now still belongs to this period
            frame_cnt <= frame_cnt + 32'd1;
            if (!ack_seen && !hit && (miss_cnt != '1))
              miss_cnt <= miss_cnt + MISS_W'(1);
            ack_seen <= 1'b0;
            if (last_frame || stop_pend || stop) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_HIGH;
              PROJ_TRG <= 1'b1;
              cnt      <= high_m1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proj_trg_gen.sv
// tb/tb_proj_trg_gen.sv - self-checking bench for proj_trg_gen
module tb_proj_trg_gen;

  localparam int      MISS_W   = 4;
  localparam longint  MISS_MAX = (64'd1 << MISS_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [31:0]       TrgPeriod = 32'd0;
  logic [31:0]       TrgHigh = 32'd0;
  logic [31:0]       TrgCount = 32'd0;
  logic [7:0]        trig_in = 8'hFF;
  logic              PROJ_TRG;
  logic              busy;
  logic              done;
  logic [31:0]       frame_cnt;
  logic [MISS_W-1:0] miss_cnt;

  int total = 0;
  int bad   = 0;

  proj_trg_gen #(.MISS_W(MISS_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .TrgPeriod (TrgPeriod),
    .TrgHigh   (TrgHigh),
    .TrgCount  (TrgCount),
    .trig_in   (trig_in),
    .PROJ_TRG  (PROJ_TRG),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: position in the run as cycle index t, phase = (t-1) mod P
  logic   e_trg = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  longint e_frames = 0, e_miss = 0;

  initial begin
    bit     run, dcyc, ack, spend;
    longint mh, mp, mn, t, frames, miss;
    run = 0; dcyc = 0; ack = 0; spend = 0;
    mh = 1; mp = 2; mn = 0; t = 0; frames = 0; miss = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        run = 0; dcyc = 0; frames = 0; miss = 0;
        e_trg = 0; e_busy = 0; e_done = 0;
      end else if (dcyc) begin
        dcyc = 0; e_done = 0; e_busy = 0;
      end else if (!run) begin
        if (start) begin
          mh = (TrgHigh == 0) ? 1 : longint'(TrgHigh);
          mp = (longint'(TrgPeriod) > mh) ? longint'(TrgPeriod) : mh + 1;
          mn = longint'(TrgCount);
          run = 1; t = 1; frames = 0; miss = 0; ack = 0; spend = 0;
          e_busy = 1; e_trg = 1;
        end
      end else begin
        if (trig_in != 8'hFF) ack = 1;
        if (stop) spend = 1;
        if (((t - 1) % mp) == mp - 1) begin
          frames = (frames + 1) & 64'hFFFF_FFFF;
          if (!ack && miss < MISS_MAX) miss++;
          ack = 0;
          if ((mn != 0 && frames == mn) || spend) begin
            run = 0; dcyc = 1; e_done = 1;
          end
        end
        t++;
        e_trg = run && (((t - 1) % mp) < mh);
      end
      e_frames = frames;
      e_miss   = miss;
    end
  end

  // Compare every output against the model on every cycle after the first edge
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("m_trg",    PROJ_TRG,  e_trg);
      chk("m_busy",   busy,      e_busy);
      chk("m_done",   done,      e_done);
      chk("m_frames", frame_cnt, e_frames);
      chk("m_miss",   miss_cnt,  e_miss);
    end
  end

  // One run: start sampled at edge 0, cycle c observed at the negedge inside it
  task automatic run_test(input logic [31:0] per, input logic [31:0] hi, input logic [31:0] cnt,
                          input int stop_at, input int restart_at, input int newper_at,
                          input int hit_p, input int hit_off, input int hit_only, input int limit,
                          output int done_at, output int busy_low_at, output int first_rise,
                          output int pulses);
    logic prev;
    @(negedge clk);
    TrgPeriod = per; TrgHigh = hi; TrgCount = cnt;
    start = 1'b1; stop = 1'b0; trig_in = 8'hFF;
    @(posedge clk);
    done_at = -1; busy_low_at = -1; first_rise = -1; pulses = 0; prev = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      stop  = (c == stop_at);
      if (c == newper_at) TrgPeriod = 32'd3;
      trig_in = (hit_p != 0 && ((c - 1) % hit_p) == hit_off &&
                 (hit_only < 0 || ((c - 1) / hit_p) == hit_only)) ? 8'hFE : 8'hFF;
      if (PROJ_TRG && !prev) begin
        pulses++;
        if (first_rise < 0) first_rise = c;
      end
      prev = PROJ_TRG;
      if (done && done_at < 0) done_at = c;
      if (!busy) begin
        busy_low_at = c;
        break;
      end
    end
    start = 1'b0; stop = 1'b0; trig_in = 8'hFF;
    if (busy_low_at < 0) chk("run_timeout", 0, 1);
  endtask

  int d_at, b_at, f_rise, npul;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_trg", PROJ_TRG, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_frames", frame_cnt, 0);
    chk("rst_miss", miss_cnt, 0);
    rst = 1'b0;

    // Basic 4-frame run with one ack per period
    run_test(10, 3, 4, -1, -1, -1, 10, 5, -1, 60, d_at, b_at, f_rise, npul);
    chk("t1_done_at", d_at, 41);
    chk("t1_busy_low", b_at, 42);
    chk("t1_first_rise", f_rise, 1);
    chk("t1_pulses", npul, 4);
    chk("t1_frames", frame_cnt, 4);
    chk("t1_miss", miss_cnt, 0);

    // Continuous run, stop in the middle of period 2
    run_test(8, 2, 0, 13, -1, -1, 0, 0, -1, 40, d_at, b_at, f_rise, npul);
    chk("t2_done_at", d_at, 17);
    chk("t2_pulses", npul, 2);
    chk("t2_frames", frame_cnt, 2);
    chk("t2_miss", miss_cnt, 2);

    // Clamped config: H=1, P=2
    run_test(0, 0, 3, -1, -1, -1, 0, 0, -1, 20, d_at, b_at, f_rise, npul);
    chk("t3_done_at", d_at, 7);
    chk("t3_pulses", npul, 3);
    chk("t3_frames", frame_cnt, 3);

    // Restart and period change mid-run are ignored
    run_test(6, 2, 3, -1, 4, 5, 0, 0, -1, 40, d_at, b_at, f_rise, npul);
    chk("t4_done_at", d_at, 19);
    chk("t4_pulses", npul, 3);
    chk("t4_frames", frame_cnt, 3);
    chk("t4_miss", miss_cnt, 3);

    // Hit only on the first cycle of period 2 is credited to period 2
    run_test(5, 2, 2, -1, -1, -1, 5, 0, 1, 30, d_at, b_at, f_rise, npul);
    chk("t5_done_at", d_at, 11);
    chk("t5_frames", frame_cnt, 2);
    chk("t5_miss", miss_cnt, 1);

    // 2^MISS_W+5 missed frames saturate the miss counter
    run_test(2, 1, 21, -1, -1, -1, 0, 0, -1, 60, d_at, b_at, f_rise, npul);
    chk("t6_done_at", d_at, 43);
    chk("t6_frames", frame_cnt, 21);
    chk("t6_miss", miss_cnt, 15);

    // Reset during HIGH aborts, then a fresh run behaves normally
    @(negedge clk);
    TrgPeriod = 32'd2; TrgHigh = 32'd1; TrgCount = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("t7_pre_trg", PROJ_TRG, 1);
    chk("t7_pre_frames", frame_cnt, 5);
    chk("t7_pre_miss", miss_cnt, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("t7_rst_trg", PROJ_TRG, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_frames", frame_cnt, 0);
    chk("t7_rst_miss", miss_cnt, 0);
    rst = 1'b0;
    run_test(4, 1, 2, -1, -1, -1, 0, 0, -1, 30, d_at, b_at, f_rise, npul);
    chk("t7_done_at", d_at, 9);
    chk("t7_first_rise", f_rise, 1);
    chk("t7_frames", frame_cnt, 2);
    chk("t7_miss", miss_cnt, 2);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
